id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU.
- Each cycle it captures decoded instruction fields from ID.
- It detects load-use hazards and inserts bubbles.
- It resolves operand hazards from the EX/MEM and MEM/WB stages.
- It drives the ALU inputs `a`, `b` and `alu_control`, plus the control bits consumed downstream.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fwd_unit.sv | 37 +++
 rtl/id_ex_stage.sv | 201 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, ALU op codes and forward-select codes
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_EXM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - per-operand bypass select from EX/MEM, MEM/WB or regfile
module fwd_unit #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data,
    output logic [1:0]        fwd_sel
);
    import cpu_pkg::*;

    logic exm_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it is never a real producer.
    always_comb begin
        exm_hit  = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
        wb_hit   = wb_reg_write && (wb_rd != '0) && (wb_rd == rs);
        fwd_data = rf_data;
        fwd_sel  = FWD_RF;
        if (exm_hit) begin
            fwd_data = exm_result;
            fwd_sel  = FWD_EXM;
        end else if (wb_hit) begin
            fwd_data = wb_data;
            fwd_sel  = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling and operand forwarding
module id_ex_stage #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alu_src,
    input  logic [2:0]        id_alu_control,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic [2:0]        ex_alu_control,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);
    import cpu_pkg::*;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic              alu_src_q, alu_src_d;
    logic [2:0]        alu_control_q, alu_control_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              reg_write_q, reg_write_d;
    logic              branch_q, branch_d;

    logic              load_use;
    logic              bubble;
    logic [XLEN-1:0]   fwd_rs2_data;

    // A load in EX cannot feed the instruction in ID this cycle; hold ID and bubble EX.
    always_comb begin
        load_use = valid_q && mem_read_q && id_valid && (rd_q != '0) &&
                   ((id_rs1 == rd_q) || (id_uses_rs2 && (id_rs2 == rd_q)));
        stall_id = load_use || ex_stall;
        bubble   = flush || (!ex_stall && load_use);
    end

    // Next EX contents: flush bubbles over a stall, a stall holds, load-use bubbles, else capture ID.
    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        alu_src_d     = alu_src_q;
        alu_control_d = alu_control_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        reg_write_d   = reg_write_q;
        branch_d      = branch_q;
        if (bubble) begin
            valid_d       = 1'b0;
            pc_d          = '0;
            imm_d         = '0;
            rd_d          = '0;
            rs1_d         = '0;
            rs2_d         = '0;
            rs1_data_d    = '0;
            rs2_data_d    = '0;
            alu_src_d     = 1'b0;
            alu_control_d = ALU_ADD;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            reg_write_d   = 1'b0;
            branch_d      = 1'b0;
        end else if (!ex_stall) begin
            valid_d       = id_valid;
            pc_d          = id_pc;
            imm_d         = id_imm;
            rd_d          = id_rd;
            rs1_d         = id_rs1;
            rs2_d         = id_rs2;
            rs1_data_d    = id_rs1_data;
            rs2_data_d    = id_rs2_data;
            alu_src_d     = id_alu_src;
            alu_control_d = id_alu_control;
            mem_read_d    = id_mem_read && id_valid;
            mem_write_d   = id_mem_write && id_valid;
            reg_write_d   = id_reg_write && id_valid;
            branch_d      = id_branch && id_valid;
        end
    end

    // EX pipeline register; reset matches a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            alu_src_q     <= 1'b0;
            alu_control_q <= ALU_ADD;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            branch_q      <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            alu_src_q     <= alu_src_d;
            alu_control_q <= alu_control_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            branch_q      <= branch_d;
        end
    end

    fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .rs            (rs1_q),
        .rf_data       (rs1_data_q),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (ex_a),
        .fwd_sel       (fwd_a_sel)
    );

    fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .rs            (rs2_q),
        .rf_data       (rs2_data_q),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2_data),
        .fwd_sel       (fwd_b_sel)
    );

    // ALU operand b takes the immediate; stores always see the bypassed rs2.
    always_comb begin
        ex_b           = alu_src_q ? imm_q : fwd_rs2_data;
        ex_store_data  = fwd_rs2_data;
        ex_valid       = valid_q;
        ex_pc          = pc_q;
        ex_imm         = imm_q;
        ex_rd          = rd_q;
        ex_alu_control = alu_control_q;
        ex_mem_read    = mem_read_q && valid_q;
        ex_mem_write   = mem_write_q && valid_q;
        ex_reg_write   = reg_write_q && valid_q;
        ex_branch      = branch_q && valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int M_STALL = 1;
    localparam int M_CTRL  = 2;
    localparam int M_A     = 4;
    localparam int M_B     = 8;
    localparam int M_PC    = 16;

    typedef struct {
        int          id;
        int          mask;
        logic        stall;
        logic        v;
        logic [2:0]  alu;
        logic        mr, mw, rw, br;
        logic [31:0] a, b, sd, pc, imm;
        logic [4:0]  rd;
        logic [1:0]  sa, sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_control;
    logic        id_mem_read, id_mem_write, id_reg_write, id_branch;
    logic        flush, ex_stall;
    logic [4:0]  exm_rd;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        stall_id, ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_branch;
    logic [2:0]  ex_alu_control;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;
    exp_t e;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_branch(id_branch),
        .flush(flush), .ex_stall(ex_stall),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_alu_control(ex_alu_control),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step%0d %s actual=%h expected=%h", id, nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            if ((x.mask & M_STALL) != 0) cmp(x.id, "stall_id", 32'(stall_id), 32'(x.stall));
            if ((x.mask & M_CTRL) != 0) begin
                cmp(x.id, "ex_valid",       32'(ex_valid),       32'(x.v));
                cmp(x.id, "ex_alu_control", 32'(ex_alu_control), 32'(x.alu));
                cmp(x.id, "ex_mem_read",    32'(ex_mem_read),    32'(x.mr));
                cmp(x.id, "ex_mem_write",   32'(ex_mem_write),   32'(x.mw));
                cmp(x.id, "ex_reg_write",   32'(ex_reg_write),   32'(x.rw));
                cmp(x.id, "ex_branch",      32'(ex_branch),      32'(x.br));
            end
            if ((x.mask & M_A) != 0) begin
                cmp(x.id, "ex_a",      ex_a,             x.a);
                cmp(x.id, "fwd_a_sel", 32'(fwd_a_sel),   32'(x.sa));
            end
            if ((x.mask & M_B) != 0) begin
                cmp(x.id, "ex_b",          ex_b,           x.b);
                cmp(x.id, "ex_store_data", ex_store_data,  x.sd);
                cmp(x.id, "fwd_b_sel",     32'(fwd_b_sel), 32'(x.sb));
            end
            if ((x.mask & M_PC) != 0) begin
                cmp(x.id, "ex_pc",  ex_pc,      x.pc);
                cmp(x.id, "ex_rd",  32'(ex_rd), 32'(x.rd));
                cmp(x.id, "ex_imm", ex_imm,     x.imm);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_new();
        e = '{default: 0};
        e.id = step;
        step++;
    endtask

    task automatic e_stall(input logic s);
        e.mask |= M_STALL;
        e.stall = s;
    endtask

    task automatic e_ctrl(input logic v, input logic [2:0] alu, input logic mr, mw, rw, br);
        e.mask |= M_CTRL;
        e.v = v; e.alu = alu; e.mr = mr; e.mw = mw; e.rw = rw; e.br = br;
    endtask

    task automatic e_a(input logic [31:0] a, input logic [1:0] s);
        e.mask |= M_A;
        e.a = a; e.sa = s;
    endtask

    task automatic e_b(input logic [31:0] b, input logic [31:0] sd, input logic [1:0] s);
        e.mask |= M_B;
        e.b = b; e.sd = sd; e.sb = s;
    endtask

    task automatic e_pc(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] imm);
        e.mask |= M_PC;
        e.pc = pc; e.rd = rd; e.imm = imm;
    endtask

    task automatic push();
        sb_q.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                          input logic uses, input logic [31:0] d1, d2, imm, input logic src,
                          input logic [2:0] alu, input logic mr, mw, rw, br);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs2 = uses; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_src = src; id_alu_control = alu;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw; id_branch = br;
    endtask

    task automatic id_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0);
    endtask

    task automatic set_exm(input logic [4:0] rd, input logic we, input logic [31:0] d);
        exm_rd = rd; exm_reg_write = we; exm_result = d;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic we, input logic [31:0] d);
        wb_rd = rd; wb_reg_write = we; wb_data = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        id_idle();
        set_exm(0, 0, 0);
        set_wb(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_a(0, FWD_RF); e_b(0, 0, FWD_RF); e_pc(0, 0, 0); push();
        tick();
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();

        // EX/MEM vs MEM/WB forwarding on a held R-type
        tick();
        set_id(1, 32'h100, 5, 6, 8, 1, 32'h11, 32'h22, 0, 0, ALU_SUB, 0, 0, 1, 0);
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        id_idle(); ex_stall = 1'b1;
        set_exm(5, 1, 32'h1234); set_wb(5, 1, 32'hAAAA);
        e_new(); e_stall(1); e_ctrl(1, ALU_SUB, 0, 0, 1, 0); e_a(32'h1234, FWD_EXM);
        e_b(32'h22, 32'h22, FWD_RF); e_pc(32'h100, 8, 0); push();
        tick();
        set_exm(0, 1, 32'h1234);
        e_new(); e_stall(1); e_ctrl(1, ALU_SUB, 0, 0, 1, 0); e_a(32'hAAAA, FWD_WB); e_pc(32'h100, 8, 0); push();
        tick();
        set_exm(6, 1, 32'h6666);
        e_new(); e_stall(1); e_a(32'hAAAA, FWD_WB); e_b(32'h6666, 32'h6666, FWD_EXM); e_pc(32'h100, 8, 0); push();
        tick();
        ex_stall = 1'b0; set_exm(0, 0, 0); set_wb(0, 0, 0);
        e_new(); e_stall(0); e_ctrl(1, ALU_SUB, 0, 0, 1, 0); e_a(32'h11, FWD_RF);
        e_b(32'h22, 32'h22, FWD_RF); e_pc(32'h100, 8, 0); push();
        tick();
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_pc(0, 0, 0); push();

        // load-use on rs2: bubble, then the consumer picks the load data from MEM/WB
        tick();
        set_id(1, 32'h200, 1, 0, 7, 0, 32'h1000, 0, 4, 1, ALU_ADD, 1, 0, 1, 0);
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        set_id(1, 32'h204, 3, 7, 9, 1, 32'h33, 32'h77, 0, 0, ALU_OR, 0, 0, 1, 0);
        e_new(); e_stall(1); e_ctrl(1, ALU_ADD, 1, 0, 1, 0); e_a(32'h1000, FWD_RF);
        e_b(4, 0, FWD_RF); e_pc(32'h200, 7, 4); push();
        tick();
        set_exm(7, 1, 32'h1004);
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_a(0, FWD_RF); e_b(0, 0, FWD_RF); e_pc(0, 0, 0); push();
        tick();
        id_idle(); set_exm(0, 0, 0); set_wb(7, 1, 32'hCAFE);
        e_new(); e_stall(0); e_ctrl(1, ALU_OR, 0, 0, 1, 0); e_a(32'h33, FWD_RF);
        e_b(32'hCAFE, 32'hCAFE, FWD_WB); e_pc(32'h204, 9, 0); push();

        // store with immediate b and bypassed store data
        tick();
        set_wb(0, 0, 0);
        set_id(1, 32'h300, 2, 4, 0, 1, 32'h20, 32'h40, 32'hFFFF_FFF0, 1, ALU_ADD, 0, 1, 0, 0);
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        id_idle(); set_exm(4, 1, 32'h55);
        e_new(); e_ctrl(1, ALU_ADD, 0, 1, 0, 0); e_a(32'h20, FWD_RF);
        e_b(32'hFFFF_FFF0, 32'h55, FWD_EXM); e_pc(32'h300, 0, 32'hFFFF_FFF0); push();

        // x0 never forwarded; then flush beats ex_stall
        tick();
        set_exm(0, 0, 0);
        set_id(1, 32'h400, 0, 0, 1, 1, 0, 0, 0, 0, ALU_XOR, 0, 0, 1, 0);
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        id_idle(); set_exm(0, 1, 32'hDEAD); set_wb(0, 1, 32'hBEEF);
        flush = 1'b1; ex_stall = 1'b1;
        e_new(); e_stall(1); e_ctrl(1, ALU_XOR, 0, 0, 1, 0); e_a(0, FWD_RF); e_b(0, 0, FWD_RF);
        e_pc(32'h400, 1, 0); push();
        tick();
        flush = 1'b0; ex_stall = 1'b0; set_exm(0, 0, 0); set_wb(0, 0, 0);
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_pc(0, 0, 0); push();

        // flush together with load-use: stall_id from load-use, EX gets a bubble
        tick();
        set_id(1, 32'h500, 1, 0, 7, 0, 32'h1000, 0, 8, 1, ALU_ADD, 1, 0, 1, 0);
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        set_id(1, 32'h504, 7, 2, 10, 0, 32'h99, 0, 0, 0, ALU_AND, 0, 0, 1, 0);
        flush = 1'b1;
        e_new(); e_stall(1); e_ctrl(1, ALU_ADD, 1, 0, 1, 0); e_pc(32'h500, 7, 8); push();
        tick();
        flush = 1'b0; id_idle();
        e_new(); e_stall(0); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_pc(0, 0, 0); push();

        // reset mid-operation discards EX
        tick();
        set_id(1, 32'h600, 1, 2, 3, 1, 32'h61, 32'h62, 0, 0, ALU_SRA, 0, 0, 1, 1);
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); push();
        tick();
        id_idle(); rst = 1'b1;
        e_new(); e_ctrl(1, ALU_SRA, 0, 0, 1, 1); e_pc(32'h600, 3, 0); push();
        tick();
        rst = 1'b0;
        e_new(); e_ctrl(0, ALU_ADD, 0, 0, 0, 0); e_a(0, FWD_RF); e_pc(0, 0, 0); push();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
